// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU execution unit.
//   - ALU opcodes (3-bit internal operation select)
//   - R-type function codes
//   - non-R alu_op class codes
//   - control FSM state type
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // Non-R alu_op classes; any alu_op with bit3 set is R-type.
    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SLTI = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XORI = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle of the ALU execution unit.
//   master (requester): start, alu_op, func, rs_val, rt_val, imm_ext, shamt
//   slave  (exec unit): result, zero, hi, lo, busy, done, illegal, dbg_state
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0; start while busy=1 is dropped. Every accepted request produces
// exactly one done pulse (one cycle); result/zero/hi/lo/illegal are valid
// while done=1. A new start may be presented in the same cycle as done.
interface alu_exec_unit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic             start;
    logic [3:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] imm_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             illegal;
    state_t           dbg_state;

    modport master (
        output start, alu_op, func, rs_val, rt_val, imm_ext, shamt,
        input  result, zero, hi, lo, busy, done, illegal, dbg_state
    );

    modport slave (
        input  start, alu_op, func, rs_val, rt_val, imm_ext, shamt,
        output result, zero, hi, lo, busy, done, illegal, dbg_state
    );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: combinational ALU control.
//   i_alu_op, i_func -> operand selects, 3-bit ALU opcode, multiply/HI/LO
//   controls and an illegal flag. With MUL_EN=0 the multiply and HI/LO
//   function codes decode as illegal.
module alu_decode
    import alu_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [3:0] i_alu_op,
    input  logic [5:0] i_func,
    output logic       o_src_a_shamt,
    output logic       o_src_b_imm,
    output logic [2:0] o_alu_ctr,
    output logic       o_is_mul,
    output logic       o_mul_signed,
    output logic       o_rd_hi,
    output logic       o_rd_lo,
    output logic       o_illegal
);
    always_comb begin
        o_src_a_shamt = 1'b0;
        o_src_b_imm   = 1'b0;
        o_alu_ctr     = ALU_ADD;
        o_is_mul      = 1'b0;
        o_mul_signed  = 1'b0;
        o_rd_hi       = 1'b0;
        o_rd_lo       = 1'b0;
        o_illegal     = 1'b0;
        if (i_alu_op[3]) begin
            case (i_func)
                F_ADD:   o_alu_ctr = ALU_ADD;
                F_SUB:   o_alu_ctr = ALU_SUB;
                F_AND:   o_alu_ctr = ALU_AND;
                F_OR:    o_alu_ctr = ALU_OR;
                F_SLT:   o_alu_ctr = ALU_SLT;
                F_SLL: begin
                    o_alu_ctr     = ALU_SLL;
                    o_src_a_shamt = 1'b1;
                end
                F_MULT: begin
                    o_is_mul     = MUL_EN;
                    o_mul_signed = MUL_EN;
                    o_illegal    = !MUL_EN;
                end
                F_MULTU: begin
                    o_is_mul  = MUL_EN;
                    o_illegal = !MUL_EN;
                end
                F_MFHI: begin
                    o_rd_hi   = MUL_EN;
                    o_illegal = !MUL_EN;
                end
                F_MFLO: begin
                    o_rd_lo   = MUL_EN;
                    o_illegal = !MUL_EN;
                end
                default: o_illegal = 1'b1;
            endcase
        end else begin
            case (i_alu_op)
                OP_ADDI: begin o_alu_ctr = ALU_ADD;  o_src_b_imm = 1'b1; end
                OP_BEQ:  begin o_alu_ctr = ALU_SUB;  end
                OP_ANDI: begin o_alu_ctr = ALU_AND;  o_src_b_imm = 1'b1; end
                OP_ORI:  begin o_alu_ctr = ALU_OR;   o_src_b_imm = 1'b1; end
                OP_SLTI: begin o_alu_ctr = ALU_SLT;  o_src_b_imm = 1'b1; end
                OP_SLTU: begin o_alu_ctr = ALU_SLTU; end
                OP_XORI: begin o_alu_ctr = ALU_XOR;  o_src_b_imm = 1'b1; end
                default: o_illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU plus iterative shift-add multiplier.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus (slave): request operands in; result/zero/hi/lo/busy/done/illegal
//                and the FSM state (dbg_state) out.
// Single-cycle ops complete on the accepting edge. A multiply runs WIDTH
// shift-add iterations (MUL), then a sign fix-up cycle (FIX) that writes
// HI/LO and pulses done.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SHW    = $clog2(WIDTH),
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_unit_if.slave    bus
);
    logic             w_src_a_shamt, w_src_b_imm, w_is_mul, w_mul_signed;
    logic             w_rd_hi, w_rd_lo, w_illegal, w_accept, w_slt, w_sltu;
    logic [2:0]       w_alu_ctr;
    logic [WIDTH-1:0] w_a, w_b, w_alu, w_res, w_abs_a, w_abs_b;

    logic [WIDTH-1:0]   r_result, r_hi, r_lo, r_mplier;
    logic [2*WIDTH-1:0] r_mcand, r_acc;
    logic [SHW-1:0]     r_cnt;
    logic               r_zero, r_busy, r_done, r_illegal, r_neg;
    state_t             r_state;

    alu_decode #(.MUL_EN(MUL_EN)) u_decode (
        .i_alu_op      (bus.alu_op),
        .i_func        (bus.func),
        .o_src_a_shamt (w_src_a_shamt),
        .o_src_b_imm   (w_src_b_imm),
        .o_alu_ctr     (w_alu_ctr),
        .o_is_mul      (w_is_mul),
        .o_mul_signed  (w_mul_signed),
        .o_rd_hi       (w_rd_hi),
        .o_rd_lo       (w_rd_lo),
        .o_illegal     (w_illegal)
    );

    assign w_accept = bus.start && !r_busy;
    assign w_a = w_src_a_shamt ? {{(WIDTH-SHW){1'b0}}, bus.shamt} : bus.rs_val;
    assign w_b = w_src_b_imm ? bus.imm_ext : bus.rt_val;
    assign w_slt  = $signed(w_a) < $signed(w_b);
    assign w_sltu = w_a < w_b;

    always_comb begin
        w_alu = '0;
        case (w_alu_ctr)
            ALU_ADD:  w_alu = w_a + w_b;
            ALU_SUB:  w_alu = w_a - w_b;
            ALU_AND:  w_alu = w_a & w_b;
            ALU_OR:   w_alu = w_a | w_b;
            ALU_SLL:  w_alu = w_b << w_a[SHW-1:0];
            ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_sltu};
            ALU_XOR:  w_alu = w_a ^ w_b;
            default:  w_alu = '0;
        endcase
    end

    assign w_res = w_rd_hi ? r_hi : (w_rd_lo ? r_lo : w_alu);

    // Signed multiply works on magnitudes; -2^(WIDTH-1) negates to itself,
    // which is the correct magnitude when read as unsigned.
    assign w_abs_a = (w_mul_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    assign w_abs_b = (w_mul_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                        end else if (w_is_mul) begin
                            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                            r_mplier <= w_abs_b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_neg    <= w_mul_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                            r_busy   <= 1'b1;
                            r_state  <= MUL;
                        end else begin
                            r_result  <= w_res;
                            r_zero    <= (w_res == '0);
                            r_done    <= 1'b1;
                            r_illegal <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    // Add the shifted multiplicand for each set multiplier bit, LSB first.
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH-1)) r_state <= FIX;
                end
                FIX: begin
                    {r_hi, r_lo} <= r_neg ? -r_acc : r_acc;
                    r_done    <= 1'b1;
                    r_illegal <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = MUL_EN ? r_busy : 1'b0;
    assign bus.done      = r_done;
    assign bus.illegal   = r_illegal;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed responses; expected
// responses are queued at issue time and checked by a monitor on done.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_count = 0;
    int   n_pushed = 0;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic z, input logic ill,
                                input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.result = res; e.zero = z; e.ill = ill; e.hi = h; e.lo = l;
        return e;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; presents one request for one cycle once busy=0.
    task automatic issue(input logic [3:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] sh,
                         input bit push, input exp_t e);
        int guard = 0;
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("issue_wait_timeout", 64'd1, 64'd0);
        bus.alu_op  = op;
        bus.func    = fn;
        bus.rs_val  = rs;
        bus.rt_val  = rt;
        bus.imm_ext = imm;
        bus.shamt   = sh;
        bus.start   = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            n_pushed++;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called right after issuing a multiply; counts busy cycles, and drops a
    // conflicting start into the middle of the multiply.
    task automatic mul_wait(input string name);
        int cnt = 0;
        chk({name, "_state_mul"}, 64'(bus.dbg_state), 64'(MUL));
        while (bus.busy && cnt < 100) begin
            cnt++;
            if (cnt == 5) begin
                bus.alu_op = 4'b1000;
                bus.func   = F_ADD;
                bus.rs_val = 32'd1;
                bus.rt_val = 32'd2;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({name, "_busy_cycles"}, 64'(cnt), 64'd33);
        chk({name, "_done_after_busy"}, 64'(bus.done), 64'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result",  64'(bus.result),  64'(e.result));
                chk("zero",    64'(bus.zero),    64'(e.zero));
                chk("illegal", 64'(bus.illegal), 64'(e.ill));
                chk("hi",      64'(bus.hi),      64'(e.hi));
                chk("lo",      64'(bus.lo),      64'(e.lo));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_t nx;
        int guard;
        nx = mk(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.start = 1'b0; bus.alu_op = '0; bus.func = '0;
        bus.rs_val = '0; bus.rt_val = '0; bus.imm_ext = '0; bus.shamt = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_result",  64'(bus.result),  64'd0);
        chk("rst_zero",    64'(bus.zero),    64'd1);
        chk("rst_hi",      64'(bus.hi),      64'd0);
        chk("rst_lo",      64'(bus.lo),      64'd0);
        chk("rst_busy",    64'(bus.busy),    64'd0);
        chk("rst_done",    64'(bus.done),    64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_state",   64'(bus.dbg_state), 64'(IDLE));

        // single-cycle ops, issued back-to-back
        issue(4'b1000, F_ADD, 32'd5, 32'd7, 32'd0, 5'd0, 1, mk(32'hC, 0, 0, 0, 0));
        issue(OP_BEQ, 6'd0, 32'h1234, 32'h1234, 32'd0, 5'd0, 1, mk(32'h0, 1, 0, 0, 0));
        issue(OP_SLTI, 6'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 5'd0, 1, mk(32'h1, 0, 0, 0, 0));
        issue(4'b1000, F_SLL, 32'hDEAD, 32'h1, 32'd0, 5'd4, 1, mk(32'h10, 0, 0, 0, 0));
        issue(4'b1000, F_SUB, 32'd5, 32'd7, 32'd0, 5'd0, 1, mk(32'hFFFFFFFE, 0, 0, 0, 0));
        issue(OP_SLTU, 6'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 1, mk(32'h0, 1, 0, 0, 0));
        issue(OP_XORI, 6'd0, 32'hF0F0, 32'd0, 32'h0FF0, 5'd0, 1, mk(32'hFF00, 0, 0, 0, 0));
        issue(OP_ANDI, 6'd0, 32'hFF00, 32'd0, 32'h0F0F, 5'd0, 1, mk(32'h0F00, 0, 0, 0, 0));
        issue(OP_ORI, 6'd0, 32'hF000, 32'd0, 32'h000F, 5'd0, 1, mk(32'hF00F, 0, 0, 0, 0));
        issue(4'b1000, F_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0, 5'd0, 1, mk(32'h0F000F00, 0, 0, 0, 0));
        issue(4'b1000, F_OR, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0, 5'd0, 1, mk(32'hFF0FFF0F, 0, 0, 0, 0));
        issue(4'b1000, F_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd0, 1, mk(32'h0, 1, 0, 0, 0));
        issue(OP_ADDI, 6'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 5'd0, 1, mk(32'h0, 1, 0, 0, 0));
        issue(4'b0100, 6'd0, 32'd9, 32'd9, 32'd9, 5'd0, 1, mk(32'h0, 1, 1, 0, 0));

        // signed multiply -3 * 7, then mflo back-to-back with done
        issue(4'b1000, F_MULT, 32'hFFFFFFFD, 32'd7, 32'd0, 5'd0, 1,
              mk(32'h0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFEB));
        mul_wait("mult");
        issue(4'b1000, F_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 1,
              mk(32'hFFFFFFEB, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB));

        // unsigned multiply of all-ones, then mfhi
        issue(4'b1000, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd0, 1,
              mk(32'hFFFFFFEB, 0, 0, 32'hFFFFFFFE, 32'h00000001));
        mul_wait("multu");
        issue(4'b1000, F_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1,
              mk(32'hFFFFFFFE, 0, 0, 32'hFFFFFFFE, 32'h00000001));

        // illegal R-type func keeps result
        issue(4'b1000, 6'b111111, 32'd3, 32'd3, 32'd0, 5'd0, 1,
              mk(32'hFFFFFFFE, 0, 1, 32'hFFFFFFFE, 32'h00000001));
        @(negedge clk);

        // asynchronous reset during MUL iteration 10
        issue(4'b1000, F_MULT, 32'd12345, 32'd678, 32'd0, 5'd0, 0, nx);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy",   64'(bus.busy),   64'd0);
        chk("abort_hi",     64'(bus.hi),     64'd0);
        chk("abort_lo",     64'(bus.lo),     64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        chk("abort_state",  64'(bus.dbg_state), 64'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_count), 64'(n_pushed));

        // most-negative operand: -2^31 * -1 = +2^31
        issue(4'b1000, F_MULT, 32'h80000000, 32'hFFFFFFFF, 32'd0, 5'd0, 1,
              mk(32'h0, 1, 0, 32'h0, 32'h80000000));
        mul_wait("mult_minint");
        issue(4'b1000, F_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 1,
              mk(32'h0, 1, 0, 32'h0, 32'h80000000));

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_count), 64'(n_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
